// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: byte-stream to configuration-chain loader.
// Accepts bitstream bytes over a valid/ready handshake, serialises them LSB
// first onto NUM_CHAINS parallel ccff_head lines, and generates prog_clk from
// clk (CLK_DIV clk cycles per phase). The fabric is held in reset until the
// load completes.
//
// Optional feature, enabled by defining FPGA_CFG_LOADER_CRC_EN: a CRC-8
// (poly 0x07, init 0x00, MSB first) is accumulated over the accepted bytes and
// checked against one trailing byte. A mismatch sets err and leaves the fabric
// in reset.
//
// Handshake: a byte transfers on every rising clk edge where
// in_valid && in_ready are both 1. in_ready is registered and falls the cycle
// after a transfer. The sender may hold in_valid low for any number of cycles.
//
// Legal parameters: NUM_CHAINS in {1,2,4,8}; CHAIN_LEN*NUM_CHAINS a multiple
// of 8; CLK_DIV >= 1.
module fpga_cfg_loader #(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 512,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  prog_clk,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  fabric_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int PULSES_PER_BYTE = 8 / NUM_CHAINS;
    localparam int CNT_W           = $clog2(CHAIN_LEN + 1);
    localparam int DIV_W           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W           = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_FINISH
`ifdef FPGA_CFG_LOADER_CRC_EN
        , S_CRC_FETCH
`endif
    } state_e;

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  prog_clk_q, prog_clk_d;
    logic [NUM_CHAINS-1:0] ccff_head_q, ccff_head_d;
    logic                  fabric_rst_n_q, fabric_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [CNT_W-1:0]      pulse_cnt_q, pulse_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_shift;
    logic                  accept;
    logic                  phase_end;

`ifdef FPGA_CFG_LOADER_CRC_EN
    logic [7:0]            crc_q, crc_d;

    // CRC-8, polynomial x^8+x^2+x+1, processed MSB first.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d        = state_q;
        in_ready_d     = in_ready_q;
        prog_clk_d     = prog_clk_q;
        ccff_head_d    = ccff_head_q;
        fabric_rst_n_d = fabric_rst_n_q;
        busy_d         = busy_q;
        done_d         = done_q;
        err_d          = err_q;
        shreg_d        = shreg_q;
        pulse_cnt_d    = pulse_cnt_q;
        div_cnt_d      = div_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_shift    = shreg_q >> NUM_CHAINS;
        accept         = in_valid && in_ready_q;
        phase_end      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
`ifdef FPGA_CFG_LOADER_CRC_EN
        crc_d          = crc_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // start is only honoured here, so a pulse while busy is ignored.
                if (start) begin
                    state_d        = S_FETCH;
                    in_ready_d     = 1'b1;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                    fabric_rst_n_d = 1'b0;
                    ccff_head_d    = '0;
                    pulse_cnt_d    = '0;
                    div_cnt_d      = '0;
                    bit_cnt_d      = '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
                    crc_d          = 8'h00;
`endif
                end
            end

            S_FETCH: begin
                // First bits of the new byte are presented while prog_clk is low.
                if (accept) begin
                    state_d     = S_SHIFT_LO;
                    in_ready_d  = 1'b0;
                    shreg_d     = in_data;
                    ccff_head_d = in_data[NUM_CHAINS-1:0];
                    div_cnt_d   = '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
                    crc_d       = crc8_update(crc_q, in_data);
`endif
                end
            end

            S_SHIFT_LO: begin
                if (phase_end) begin
                    state_d    = S_SHIFT_HI;
                    prog_clk_d = 1'b1;
                    div_cnt_d  = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_SHIFT_HI: begin
                // Data only moves on the falling transition, keeping it stable
                // for a full phase on either side of the rising edge.
                if (phase_end) begin
                    prog_clk_d  = 1'b0;
                    div_cnt_d   = '0;
                    shreg_d     = shreg_shift;
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                    if (pulse_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        bit_cnt_d = '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
                        state_d    = S_CRC_FETCH;
                        in_ready_d = 1'b1;
`else
                        state_d    = S_FINISH;
`endif
                    end else if (bit_cnt_q == BIT_W'(PULSES_PER_BYTE - 1)) begin
                        bit_cnt_d  = '0;
                        state_d    = S_FETCH;
                        in_ready_d = 1'b1;
                    end else begin
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        ccff_head_d = shreg_shift[NUM_CHAINS-1:0];
                        state_d     = S_SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                busy_d         = 1'b0;
                done_d         = 1'b1;
                fabric_rst_n_d = 1'b1;
                ccff_head_d    = '0;
                state_d        = S_IDLE;
            end

`ifdef FPGA_CFG_LOADER_CRC_EN
            S_CRC_FETCH: begin
                // Trailing byte carries the expected CRC of the whole bitstream.
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (in_data == crc_q) begin
                        state_d = S_FINISH;
                    end else begin
                        err_d       = 1'b1;
                        done_d      = 1'b0;
                        busy_d      = 1'b0;
                        ccff_head_d = '0;
                        state_d     = S_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            in_ready_q     <= 1'b0;
            prog_clk_q     <= 1'b0;
            ccff_head_q    <= '0;
            fabric_rst_n_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            shreg_q        <= 8'h00;
            pulse_cnt_q    <= '0;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_q          <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            prog_clk_q     <= prog_clk_d;
            ccff_head_q    <= ccff_head_d;
            fabric_rst_n_q <= fabric_rst_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            shreg_q        <= shreg_d;
            pulse_cnt_q    <= pulse_cnt_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_q          <= crc_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign prog_clk     = prog_clk_q;
    assign ccff_head    = ccff_head_q;
    assign fabric_rst_n = fabric_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Testbench for fpga_cfg_loader. Two instances: a single-chain loader
// (CHAIN_LEN=16) and a four-chain loader (CHAIN_LEN=4), both CLK_DIV=2.
// Defining FPGA_CFG_LOADER_CRC_EN also enables the trailing-CRC scenarios.
module tb_fpga_cfg_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Single-chain instance
    logic       start1    = 1'b0;
    logic       in_valid1 = 1'b0;
    logic [7:0] in_data1  = 8'h00;
    logic       in_ready1, prog_clk1, fabric_rst_n1, busy1, done1, err1;
    logic [0:0] head1;

    // Four-chain instance
    logic       start4    = 1'b0;
    logic       in_valid4 = 1'b0;
    logic [7:0] in_data4  = 8'h00;
    logic       in_ready4, prog_clk4, fabric_rst_n4, busy4, done4, err4;
    logic [3:0] head4;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // prog_clk edge monitor state
    int         cyc        = 0;
    int         edges1     = 0;
    int         edges4     = 0;
    int         last_rise1 = 0;
    int         last_rise4 = 0;
    int         period1    = 0;
    int         period4    = 0;
    logic       prev1      = 1'b0;
    logic       prev4      = 1'b0;
    logic [0:0] heads1[$];
    logic [3:0] heads4[$];

    // Expected streams: pulse i of the single chain carries bit i of {3C,A5}
    logic [15:0] exp_bits1 = 16'h3CA5;
    logic [3:0]  exp4[4]   = '{4'h1, 4'h2, 4'h4, 4'h8};

`ifdef FPGA_CFG_LOADER_CRC_EN
    logic [7:0] crc1 = 8'h00;
    logic [7:0] crc4 = 8'h00;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    fpga_cfg_loader #(.NUM_CHAINS(1), .CHAIN_LEN(16), .CLK_DIV(2)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start1),
        .in_data      (in_data1),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .prog_clk     (prog_clk1),
        .ccff_head    (head1),
        .fabric_rst_n (fabric_rst_n1),
        .busy         (busy1),
        .done         (done1),
        .err          (err1)
    );

    fpga_cfg_loader #(.NUM_CHAINS(4), .CHAIN_LEN(4), .CLK_DIV(2)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start4),
        .in_data      (in_data4),
        .in_valid     (in_valid4),
        .in_ready     (in_ready4),
        .prog_clk     (prog_clk4),
        .ccff_head    (head4),
        .fabric_rst_n (fabric_rst_n4),
        .busy         (busy4),
        .done         (done4),
        .err          (err4)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record ccff_head at each prog_clk rising edge, plus edge count and period.
    always @(negedge clk) begin
        cyc++;
        if (prog_clk1 && !prev1) begin
            edges1++;
            heads1.push_back(head1);
            period1    = cyc - last_rise1;
            last_rise1 = cyc;
        end
        if (prog_clk4 && !prev4) begin
            edges4++;
            heads4.push_back(head4);
            period4    = cyc - last_rise4;
            last_rise4 = cyc;
        end
        prev1 = prog_clk1;
        prev4 = prog_clk4;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 1) start1 = 1'b1;
        else          start4 = 1'b1;
`ifdef FPGA_CFG_LOADER_CRC_EN
        if (sel == 1) crc1 = 8'h00;
        else          crc4 = 8'h00;
`endif
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        int   n;
        logic rdy;
        n = 0;
        if (sel == 1) begin in_data1 = b; in_valid1 = 1'b1; end
        else          begin in_data4 = b; in_valid4 = 1'b1; end
        rdy = (sel == 1) ? in_ready1 : in_ready4;
        while (!rdy && n < 400) begin
            @(negedge clk);
            n++;
            rdy = (sel == 1) ? in_ready1 : in_ready4;
        end
        if (rdy) begin
            @(negedge clk);
`ifdef FPGA_CFG_LOADER_CRC_EN
            if (sel == 1) crc1 = crc8_upd(crc1, b);
            else          crc4 = crc8_upd(crc4, b);
`endif
        end
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        cmp_cnt++;
        if (!rdy) begin
            err_cnt++;
            $display("FAIL send_byte%0d_accept: byte %h not accepted after %0d cycles, in_ready required 1", sel, b, n);
        end
    endtask

    task automatic wait_done(input int sel);
        int   n;
        logic fin;
        n   = 0;
        fin = (sel == 1) ? (done1 | err1) : (done4 | err4);
        while (!fin && n < 1000) begin
            @(negedge clk);
            n++;
            fin = (sel == 1) ? (done1 | err1) : (done4 | err4);
        end
        cmp_cnt++;
        if (!fin) begin
            err_cnt++;
            $display("FAIL wait_done%0d: done/err still 0 after %0d cycles, required 1", sel, n);
        end
    endtask

    // Sends the trailing CRC byte when that feature is built in, then waits.
    task automatic finish_load(input int sel);
`ifdef FPGA_CFG_LOADER_CRC_EN
        send_byte(sel, (sel == 1) ? crc1 : crc4);
`endif
        wait_done(sel);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if ({in_ready1, prog_clk1, head1, fabric_rst_n1, busy1, done1, err1} !== 7'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs1: got %b required 0000000",
                     {in_ready1, prog_clk1, head1, fabric_rst_n1, busy1, done1, err1});
        end
        cmp_cnt++;
        if ({in_ready4, prog_clk4, head4, fabric_rst_n4, busy4, done4, err4} !== 10'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs4: got %b required 0000000000",
                     {in_ready4, prog_clk4, head4, fabric_rst_n4, busy4, done4, err4});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_load();
        int be, bq;
        be = edges1;
        bq = heads1.size();
        pulse_start(1);
        cmp_cnt++;
        if ({busy1, fabric_rst_n1, in_ready1, done1} !== 4'b1010) begin
            err_cnt++;
            $display("FAIL basic_start_status: busy,frst,rdy,done=%b required 1010",
                     {busy1, fabric_rst_n1, in_ready1, done1});
        end
        send_byte(1, 8'hA5);
        send_byte(1, 8'h3C);
        finish_load(1);
        cmp_cnt++;
        if (edges1 - be != 16) begin
            err_cnt++;
            $display("FAIL basic_edges: got %0d required 16", edges1 - be);
        end
        for (int i = 0; i < 16; i++) begin
            cmp_cnt++;
            if (heads1[bq + i] !== exp_bits1[i]) begin
                err_cnt++;
                $display("FAIL basic_bit%0d: got %b required %b", i, heads1[bq + i], exp_bits1[i]);
            end
        end
        cmp_cnt++;
        if (period1 != 4) begin
            err_cnt++;
            $display("FAIL basic_period: got %0d required 4", period1);
        end
        cmp_cnt++;
        if ({done1, fabric_rst_n1, busy1, err1, in_ready1} !== 5'b11000) begin
            err_cnt++;
            $display("FAIL basic_end_status: done,frst,busy,err,rdy=%b required 11000",
                     {done1, fabric_rst_n1, busy1, err1, in_ready1});
        end
    endtask

    task automatic test_parallel_chains();
        int be, bq;
        be = edges4;
        bq = heads4.size();
        pulse_start(4);
        send_byte(4, 8'h21);
        send_byte(4, 8'h84);
        finish_load(4);
        cmp_cnt++;
        if (edges4 - be != 4) begin
            err_cnt++;
            $display("FAIL par_edges: got %0d required 4", edges4 - be);
        end
        for (int i = 0; i < 4; i++) begin
            cmp_cnt++;
            if (heads4[bq + i] !== exp4[i]) begin
                err_cnt++;
                $display("FAIL par_edge%0d: got %h required %h", i, heads4[bq + i], exp4[i]);
            end
        end
        cmp_cnt++;
        if (period4 != 4) begin
            err_cnt++;
            $display("FAIL par_period: got %0d required 4", period4);
        end
        cmp_cnt++;
        if ({done4, fabric_rst_n4, busy4, err4} !== 4'b1100) begin
            err_cnt++;
            $display("FAIL par_end_status: done,frst,busy,err=%b required 1100",
                     {done4, fabric_rst_n4, busy4, err4});
        end
    endtask

    task automatic test_stall_ignored_start();
        int be, e0, bad, n;
        be = edges1;
        pulse_start(1);
        send_byte(1, 8'hA5);
        n = 0;
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmp_cnt++;
        if (in_ready1 !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_refetch: in_ready=%b after %0d cycles, required 1", in_ready1, n);
        end
        e0  = edges1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start1 = (i == 10);
            if (prog_clk1 !== 1'b0) bad++;
        end
        start1 = 1'b0;
        cmp_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL stall_prog_clk: prog_clk high on %0d cycles, required 0", bad);
        end
        cmp_cnt++;
        if (edges1 != e0) begin
            err_cnt++;
            $display("FAIL stall_edges: got %0d extra edges, required 0", edges1 - e0);
        end
        cmp_cnt++;
        if ({busy1, in_ready1, fabric_rst_n1} !== 3'b110) begin
            err_cnt++;
            $display("FAIL stall_status: busy,rdy,frst=%b required 110", {busy1, in_ready1, fabric_rst_n1});
        end
        send_byte(1, 8'h3C);
        finish_load(1);
        cmp_cnt++;
        if (edges1 - be != 16) begin
            err_cnt++;
            $display("FAIL stall_total_edges: got %0d required 16", edges1 - be);
        end
        cmp_cnt++;
        if (done1 !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_done: got %b required 1", done1);
        end
    endtask

    task automatic test_no_extra_accept();
        int seen;
        seen = 0;
        in_data1  = 8'hFF;
        in_valid1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready1 !== 1'b0) seen++;
        end
        in_valid1 = 1'b0;
        cmp_cnt++;
        if (seen != 0) begin
            err_cnt++;
            $display("FAIL extra_byte_ready: in_ready high on %0d cycles, required 0", seen);
        end
        cmp_cnt++;
        if ({done1, fabric_rst_n1, busy1} !== 3'b110) begin
            err_cnt++;
            $display("FAIL idle_hold: done,frst,busy=%b required 110", {done1, fabric_rst_n1, busy1});
        end
    endtask

    task automatic test_restart_abort();
        int be, bq, n;
        pulse_start(1);
        cmp_cnt++;
        if ({fabric_rst_n1, done1, busy1} !== 3'b001) begin
            err_cnt++;
            $display("FAIL restart_status: frst,done,busy=%b required 001", {fabric_rst_n1, done1, busy1});
        end
        be = edges1;
        send_byte(1, 8'hA5);
        n = 0;
        while (edges1 - be < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmp_cnt++;
        if (edges1 - be < 5) begin
            err_cnt++;
            $display("FAIL abort_edges: got %0d edges, required 5", edges1 - be);
        end
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({prog_clk1, fabric_rst_n1, busy1, in_ready1, done1, head1} !== 6'b0) begin
            err_cnt++;
            $display("FAIL abort_outputs: pclk,frst,busy,rdy,done,head=%b required 000000",
                     {prog_clk1, fabric_rst_n1, busy1, in_ready1, done1, head1});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        be = edges1;
        bq = heads1.size();
        pulse_start(1);
        send_byte(1, 8'hA5);
        send_byte(1, 8'h3C);
        finish_load(1);
        cmp_cnt++;
        if (edges1 - be != 16) begin
            err_cnt++;
            $display("FAIL reload_edges: got %0d required 16", edges1 - be);
        end
        for (int i = 0; i < 16; i++) begin
            cmp_cnt++;
            if (heads1[bq + i] !== exp_bits1[i]) begin
                err_cnt++;
                $display("FAIL reload_bit%0d: got %b required %b", i, heads1[bq + i], exp_bits1[i]);
            end
        end
        cmp_cnt++;
        if ({done1, fabric_rst_n1, busy1} !== 3'b110) begin
            err_cnt++;
            $display("FAIL reload_status: done,frst,busy=%b required 110", {done1, fabric_rst_n1, busy1});
        end
    endtask

`ifdef FPGA_CFG_LOADER_CRC_EN
    task automatic test_crc();
        // CRC-8/0x07 over A5,3C is ED.
        pulse_start(1);
        send_byte(1, 8'hA5);
        send_byte(1, 8'h3C);
        send_byte(1, 8'hED);
        wait_done(1);
        cmp_cnt++;
        if ({done1, err1, fabric_rst_n1, busy1} !== 4'b1010) begin
            err_cnt++;
            $display("FAIL crc_good: done,err,frst,busy=%b required 1010", {done1, err1, fabric_rst_n1, busy1});
        end
        pulse_start(1);
        send_byte(1, 8'hA5);
        send_byte(1, 8'h3C);
        send_byte(1, 8'h00);
        wait_done(1);
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if ({done1, err1, fabric_rst_n1, busy1} !== 4'b0100) begin
            err_cnt++;
            $display("FAIL crc_bad: done,err,frst,busy=%b required 0100", {done1, err1, fabric_rst_n1, busy1});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_parallel_chains();
        test_stall_ignored_start();
        test_no_extra_accept();
        test_restart_abort();
`ifdef FPGA_CFG_LOADER_CRC_EN
        test_crc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
